// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma keypress path.
// Alphabet size, default notches, controller states, modular increment.
package enigma_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;
  localparam int NOTCH1_DEF  = 16;
  localparam int NOTCH2_DEF  = 4;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef struct packed {
    letter_t r1;
    letter_t r2;
    letter_t r3;
  } pos_t;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    EVAL,
    OUT
  } state_t;

  function automatic logic is_letter(
    input letter_t v
  );
    return 32'(v) < 32'(NUM_LETTERS);
  endfunction

  function automatic letter_t inc_mod(
    input letter_t     v,
    input int unsigned n
  );
    if (32'(v) + 32'd1 >= n) return '0;
    return v + letter_t'(1);
  endfunction

endpackage

// File: rtl/enigma_stepper.sv
// Next rotor positions for one keypress, including the double-step.
// Purely combinational; all three rotors move from pre-step values.
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned N = NUM_LETTERS
) (
  input  letter_t r1,
  input  letter_t r2,
  input  letter_t r3,
  input  letter_t notch1,
  input  letter_t notch2,
  output letter_t n1,
  output letter_t n2,
  output letter_t n3
);

  logic carry2;
  logic carry3;

  // r2 sitting on its notch moves itself too: the double-step
  assign carry3 = (r2 == notch2);
  assign carry2 = (r1 == notch1) || carry3;

  assign n1 = inc_mod(r1, N);
  assign n2 = carry2 ? inc_mod(r2, N) : r2;
  assign n3 = carry3 ? inc_mod(r3, N) : r3;

endmodule

// File: rtl/enigma_step_controller.sv
// One-keypress-at-a-time sequencer: step rotors, settle chain, return result.
// Owns rotor positions; valid/ready on both the letter and result sides.
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int NOTCH1      = NOTCH1_DEF,
  parameter int NOTCH2      = NOTCH2_DEF,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_load,
  input  logic [LETTER_W-1:0] cfg_r1,
  input  logic [LETTER_W-1:0] cfg_r2,
  input  logic [LETTER_W-1:0] cfg_r3,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LETTER_W-1:0] in_data,
  output logic [LETTER_W-1:0] scr_letter,
  input  logic [LETTER_W-1:0] scr_result,
  output logic [LETTER_W-1:0] rotor1_pos,
  output logic [LETTER_W-1:0] rotor2_pos,
  output logic [LETTER_W-1:0] rotor3_pos,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LETTER_W-1:0] out_data,
  output logic                busy,
  output logic                err
);

  localparam int CNT_W =
    (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(EVAL_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  pos_t             pos;
  pos_t             pos_nx;
  logic [CNT_W-1:0] cnt;
  logic             cfg_ok1;
  logic             cfg_ok2;
  logic             cfg_ok3;
  logic             key_ok;

  enigma_stepper #(
    .N(NUM_LETTERS)
  ) u_stepper (
    .r1    (pos.r1),
    .r2    (pos.r2),
    .r3    (pos.r3),
    .notch1(letter_t'(NOTCH1)),
    .notch2(letter_t'(NOTCH2)),
    .n1    (pos_nx.r1),
    .n2    (pos_nx.r2),
    .n3    (pos_nx.r3)
  );

  assign cfg_ok1 = is_letter(cfg_r1);
  assign cfg_ok2 = is_letter(cfg_r2);
  assign cfg_ok3 = is_letter(cfg_r3);
  assign key_ok  = is_letter(in_data);

  assign in_ready   = (state == IDLE) && !cfg_load;
  assign busy       = (state != IDLE);
  assign rotor1_pos = pos.r1;
  assign rotor2_pos = pos.r2;
  assign rotor3_pos = pos.r3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid && in_ready && key_ok) state_nx = STEP;
      STEP: state_nx = EVAL;
      EVAL: if (cnt == '0) state_nx = OUT;
      OUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos        <= '0;
      scr_letter <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          // load takes priority over a letter offered the same cycle
          if (cfg_load) begin
            pos.r1 <= cfg_ok1 ? cfg_r1 : '0;
            pos.r2 <= cfg_ok2 ? cfg_r2 : '0;
            pos.r3 <= cfg_ok3 ? cfg_r3 : '0;
            err    <= !(cfg_ok1 && cfg_ok2 && cfg_ok3);
          end else if (in_valid) begin
            if (key_ok) scr_letter <= in_data;
            else        err        <= 1'b1;
          end
        end
        STEP: begin
          pos <= pos_nx;
          cnt <= CNT_INIT;
        end
        EVAL: begin
          if (cnt == '0) begin
            out_data  <= scr_result;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_step_controller.sv
// Randomized bench with scoreboard for enigma_step_controller.
// A stub rotor chain feeds scr_result; a monitor checks every handshake.
module tb_enigma_step_controller;

  localparam int NL  = 26;
  localparam int K1  = 16;
  localparam int K2  = 4;
  localparam int EVC = 1;

  typedef struct {
    int d;
    int p1;
    int p2;
    int p3;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cfg_load;
  logic [4:0] cfg_r1;
  logic [4:0] cfg_r2;
  logic [4:0] cfg_r3;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic [4:0] scr_letter;
  logic [4:0] scr_result;
  logic [4:0] rotor1_pos;
  logic [4:0] rotor2_pos;
  logic [4:0] rotor3_pos;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       busy;
  logic       err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   m1 = 0;
  int   m2 = 0;
  int   m3 = 0;
  bit   rand_mode = 0;
  bit   prev_ov = 0;
  exp_t sb[$];

  enigma_step_controller #(
    .NOTCH1     (K1),
    .NOTCH2     (K2),
    .EVAL_CYCLES(EVC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_r1    (cfg_r1),
    .cfg_r2    (cfg_r2),
    .cfg_r3    (cfg_r3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .scr_letter(scr_letter),
    .scr_result(scr_result),
    .rotor1_pos(rotor1_pos),
    .rotor2_pos(rotor2_pos),
    .rotor3_pos(rotor3_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  function automatic int chain(int l, int a, int b, int c);
    return (l + a + 3 * b + 7 * c + 11) % NL;
  endfunction

  assign scr_result = 5'(chain(int'(scr_letter), int'(rotor1_pos),
                               int'(rotor2_pos), int'(rotor3_pos)));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    bit c2;
    bit c3;
    c3 = (m2 == K2);
    c2 = (m1 == K1) || c3;
    m1 = (m1 + 1) % NL;
    if (c2) m2 = (m2 + 1) % NL;
    if (c3) m3 = (m3 + 1) % NL;
  endtask

  task automatic pos_vs_model(input string tag);
    chk({tag, "_r1"}, int'(rotor1_pos), m1);
    chk({tag, "_r2"}, int'(rotor2_pos), m2);
    chk({tag, "_r3"}, int'(rotor3_pos), m3);
  endtask

  task automatic expect_pos(input int a, input int b, input int c);
    chk("pos_r1", int'(rotor1_pos), a);
    chk("pos_r2", int'(rotor2_pos), b);
    chk("pos_r3", int'(rotor3_pos), c);
  endtask

  task automatic press(input int d);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 5'(d);
    @(posedge clk);
    if (d < NL) begin
      model_step();
      e.d  = chain(d, m1, m2, m3);
      e.p1 = m1;
      e.p2 = m2;
      e.p3 = m3;
      sb.push_back(e);
    end
    #1;
    in_valid   = 1'b0;
    accept_cyc = cyc;
    if (d < NL) begin
      chk("busy_after_accept", int'(busy), 1);
      chk("err_on_valid", int'(err), 0);
    end else begin
      chk("err_pulse", int'(err), 1);
      chk("busy_invalid", int'(busy), 0);
      pos_vs_model("invalid_keep");
      tick();
      chk("err_clear", int'(err), 0);
      chk("no_out_valid", int'(out_valid), 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 200) begin
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic load(input int a, input int b, input int c,
                      input bit with_key);
    bit bad;
    cfg_load = 1'b1;
    cfg_r1   = 5'(a);
    cfg_r2   = 5'(b);
    cfg_r3   = 5'(c);
    if (with_key) begin
      in_valid = 1'b1;
      in_data  = 5'd3;
    end
    #1;
    chk("ready_during_load", int'(in_ready), 0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    bad = (a >= NL) || (b >= NL) || (c >= NL);
    m1 = (a < NL) ? a : 0;
    m2 = (b < NL) ? b : 0;
    m3 = (c < NL) ? c : 0;
    chk("cfg_err", int'(err), int'(bad));
    chk("busy_after_load", int'(busy), 0);
    pos_vs_model("load");
    tick();
    chk("cfg_err_clear", int'(err), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov)
        chk("latency", cyc - accept_cyc, 1 + EVC);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", int'(out_data), e.d);
          chk("out_r1", int'(rotor1_pos), e.p1);
          chk("out_r2", int'(rotor2_pos), e.p2);
          chk("out_r3", int'(rotor3_pos), e.p3);
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    logic [4:0] hold;
    int         n;
    rst       = 1'b0;
    cfg_load  = 1'b0;
    cfg_r1    = '0;
    cfg_r2    = '0;
    cfg_r3    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_letter", int'(scr_letter), 0);
    chk("rst_err", int'(err), 0);
    expect_pos(0, 0, 0);
    rst = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);

    press(0);
    wait_idle();
    expect_pos(1, 0, 0);

    load(16, 0, 0, 0);
    press(4);
    wait_idle();
    expect_pos(17, 1, 0);
    press(19);
    wait_idle();
    expect_pos(18, 1, 0);

    load(16, 3, 0, 0);
    press(1);
    wait_idle();
    expect_pos(17, 4, 0);
    press(2);
    wait_idle();
    expect_pos(18, 5, 1);
    press(25);
    wait_idle();
    expect_pos(19, 5, 1);

    load(25, 25, 25, 0);
    press(12);
    wait_idle();
    expect_pos(0, 25, 25);
    press(26);
    expect_pos(0, 25, 25);
    load(30, 2, 2, 0);
    expect_pos(0, 2, 2);

    out_ready = 1'b0;
    press(7);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_out_valid", int'(out_valid), 1);
    hold = out_data;
    repeat (5) begin
      tick();
      chk("bp_data_stable", int'(out_data), int'(hold));
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_release_valid", int'(out_valid), 0);
    expect_pos(1, 2, 2);

    load(5, 6, 7, 1);
    expect_pos(5, 6, 7);

    press(9);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_letter", int'(scr_letter), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    expect_pos(0, 0, 0);
    sb.delete();
    m1 = 0;
    m2 = 0;
    m3 = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_no_output", int'(out_valid), 0);

    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), 0);
      end else begin
        press(int'($urandom_range(0, 31)));
        wait_idle();
        pos_vs_model("rand");
      end
    end
    rand_mode = 0;
    out_ready = 1'b1;
    wait_idle();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enigma_step_controller.md
Name: enigma_step_controller

Overview:
Sequences one keypress at a time through the three-rotor scrambler path. It owns the rotor position registers and applies Enigma stepping, including double-step, before each evaluation. It drives the positions and the held letter into the combinational rotor chain, waits a fixed settle time, then captures and returns the result over a valid/ready interface. It sits between the keyboard/UART front end and the rotor0/rotor1/rotor2 chain, replacing the free-running rotation engine.

Parameters:
NUM_LETTERS, 26, alphabet size; positions and letters are 0..NUM_LETTERS-1.
NOTCH1, 16, rotor1 (fast) position at which rotor2 is carried.
NOTCH2, 4, rotor2 position at which rotor3 is carried (double-step source).
EVAL_CYCLES, 1, settle cycles (>=1) allowed for the combinational rotor chain.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
cfg_load  in  1  load initial positions (honoured only in IDLE)
cfg_r1 / cfg_r2 / cfg_r3  in  5 each  initial positions
in_valid  in  1  letter offered
in_ready  out  1  controller accepts letter
in_data  in  5  letter code
scr_letter  out  5  registered letter driven to rotor chain input
scr_result  in  5  rotor chain output
rotor1_pos / rotor2_pos / rotor3_pos  out  5 each  registered positions to rotor chain
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  5  scrambled letter (registered)
busy  out  1  state != IDLE
err  out  1  one-cycle pulse: invalid letter or invalid cfg value

Behaviour:
- Reset (rst=0, async): state IDLE, all positions 0, scr_letter 0, out_data 0, out_valid 0, err 0, busy 0. Reset mid-operation aborts the keypress; no output is produced.
- States: IDLE -> STEP -> EVAL -> OUT -> IDLE.
- in_ready = (state==IDLE) && !cfg_load. All outputs are registered except in_ready and busy.
- IDLE, cfg_load=1: load cfg_rN; any value >= NUM_LETTERS loads as 0 for that rotor and pulses err. cfg_load wins over a simultaneous in_valid. cfg_load outside IDLE is ignored.
- IDLE, in_valid && in_ready:
  - in_data < NUM_LETTERS: latch into scr_letter, go to STEP.
  - in_data >= NUM_LETTERS: consume it, pulse err, stay in IDLE. Positions do not change.
- STEP (1 cycle): update all positions in one edge, based on pre-step values:
  - r1 steps always.
  - r2 steps if r1==NOTCH1 or r2==NOTCH2 (the second condition is the double-step).
  - r3 steps if r2==NOTCH2.
  - Increment is mod NUM_LETTERS: 25 -> 0. r3 never carries further.
  - Go to EVAL; settle counter = EVAL_CYCLES-1.
- EVAL: count down. On the edge where the counter is 0, capture scr_result into out_data, set out_valid=1, go to OUT.
- Latency: accept at edge T, positions update at T+1, out_valid rises at T+1+EVAL_CYCLES (T+2 with default parameters).
- OUT: hold out_data and out_valid stable while out_ready=0. On out_valid && out_ready: clear out_valid, return to IDLE. in_ready rises the following cycle, so there is at most one keypress in flight.
- Positions and scr_letter are stable from STEP until the next accept or load.

Decomposition:
- enigma_pkg holds: LETTER_W=5, NUM_LETTERS, default notch constants, the state enum (IDLE/STEP/EVAL/OUT), and a mod-26 increment function.
- One sub-module, enigma_stepper: combinational next-position logic. Inputs r1/r2/r3 and the notches; outputs next r1/r2/r3. It is unit-testable on its own.

Test Plan:
1. Reset, then press in_data=0 with out_ready=1 and the bench rotor model → positions (1,0,0). out_valid rises exactly 2 cycles after accept. out_data equals the model result for the letter at (1,0,0). err=0.
2. cfg_load (16,0,0), press → (17,1,0). Press again → (18,1,0).
3. Double-step: cfg_load (16,3,0), press → (17,4,0). Press → (18,5,1). Press → (19,5,1).
4. Wrap and invalid input: cfg_load (25,25,25), press → (0,25,25). Press in_data=26 → err pulse for 1 cycle, positions unchanged, no out_valid. cfg_load (30,2,2) → positions (0,2,2) and an err pulse.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0, busy=1. The cycle after out_ready=1 handshakes → in_ready=1.
6. Conflicts: assert cfg_load and in_valid together in IDLE → load wins, in_ready=0, no step. Assert rst low during EVAL → all outputs 0 immediately, state IDLE.
